// File: rtl/down_counter16_event_detector.sv
// rtl/down_counter16_event_detector.sv - match/wrap/done event detector fed by a 16-bit down counter
module down_counter16_event_detector #(
    parameter int WIDTH     = 16,
    parameter int EVT_WIDTH = 8
) (
    input  logic                 clock0,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     count_in,
    input  logic                 enable,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [WIDTH-1:0]     cfg_match,
    input  logic [EVT_WIDTH-1:0] cfg_repeat,
    output logic                 match_pulse,
    output logic                 wrap_pulse,
    output logic [EVT_WIDTH-1:0] event_count,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     prev_cnt_q;
    logic                 prev_vld_q;
    logic [WIDTH-1:0]     match_q, match_d;
    logic [EVT_WIDTH-1:0] tgt_q, tgt_d;
    logic [EVT_WIDTH-1:0] evt_cnt_q, evt_cnt_d;
    logic                 match_pulse_q, wrap_pulse_q;

    logic                 new_val;
    logic                 wrap_det;
    logic                 accept;
    logic                 qual_match;
    logic                 last_match;
    logic [EVT_WIDTH-1:0] evt_cnt_inc;

    // A value held by the upstream counter qualifies once, on the cycle it first appears.
    assign new_val     = !prev_vld_q || (count_in != prev_cnt_q);
    assign wrap_det    = prev_vld_q && (prev_cnt_q == '0) && (count_in == {WIDTH{1'b1}});
    assign accept      = cfg_valid && cfg_ready;
    assign qual_match  = (state_q == ST_ARMED) && enable && new_val &&
                         (count_in == match_q) && (evt_cnt_q != tgt_q);
    assign evt_cnt_inc = evt_cnt_q + EVT_WIDTH'(1);
    assign last_match  = qual_match && (evt_cnt_inc == tgt_q);

    always_ff @(posedge clock0 or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept)     state_d = ST_ARMED;
            ST_ARMED: if (last_match) state_d = ST_DONE;
            ST_DONE:  if (accept)     state_d = ST_ARMED;
            default:                  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cfg_ready = (state_q != ST_ARMED);
        busy      = (state_q == ST_ARMED);
        done      = (state_q == ST_DONE);
    end

    // A repeat count of zero would never finish, so it is promoted to one.
    always_comb begin
        match_d   = match_q;
        tgt_d     = tgt_q;
        evt_cnt_d = evt_cnt_q;
        if (accept) begin
            match_d   = cfg_match;
            tgt_d     = (cfg_repeat == '0) ? EVT_WIDTH'(1) : cfg_repeat;
            evt_cnt_d = '0;
        end else if (qual_match) begin
            evt_cnt_d = evt_cnt_inc;
        end
    end

    always_ff @(posedge clock0 or posedge reset) begin
        if (reset) begin
            prev_cnt_q    <= '0;
            prev_vld_q    <= 1'b0;
            match_q       <= '0;
            tgt_q         <= '0;
            evt_cnt_q     <= '0;
            match_pulse_q <= 1'b0;
            wrap_pulse_q  <= 1'b0;
        end else begin
            prev_cnt_q    <= count_in;
            prev_vld_q    <= 1'b1;
            match_q       <= match_d;
            tgt_q         <= tgt_d;
            evt_cnt_q     <= evt_cnt_d;
            match_pulse_q <= qual_match;
            wrap_pulse_q  <= wrap_det;
        end
    end

    assign match_pulse = match_pulse_q;
    assign wrap_pulse  = wrap_pulse_q;
    assign event_count = evt_cnt_q;

endmodule

// File: tb/tb_down_counter16_event_detector.sv
// tb/tb_down_counter16_event_detector.sv - scoreboard bench for down_counter16_event_detector
module tb_down_counter16_event_detector;

    localparam int M_IDLE  = 0;
    localparam int M_ARMED = 1;
    localparam int M_DONE  = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] count_in = 16'h0000;
    logic        enable = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [15:0] cfg_match = 16'h0000;
    logic [7:0]  cfg_repeat = 8'h00;
    logic        match_pulse;
    logic        wrap_pulse;
    logic [7:0]  event_count;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    down_counter16_event_detector #(.WIDTH(16), .EVT_WIDTH(8)) dut (
        .clock0      (clk),
        .reset       (reset),
        .count_in    (count_in),
        .enable      (enable),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_match   (cfg_match),
        .cfg_repeat  (cfg_repeat),
        .match_pulse (match_pulse),
        .wrap_pulse  (wrap_pulse),
        .event_count (event_count),
        .busy        (busy),
        .done        (done)
    );

    typedef struct packed {
        logic       mp;
        logic       wp;
        logic [7:0] ec;
        logic       busy;
        logic       done;
        logic       rdy;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    int          m_state;
    logic [15:0] m_prev;
    logic        m_pvld;
    logic [15:0] m_match;
    logic [7:0]  m_tgt;
    logic [7:0]  m_cnt;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic model_reset();
        m_state = M_IDLE;
        m_prev  = 16'h0000;
        m_pvld  = 1'b0;
        m_match = 16'h0000;
        m_tgt   = 8'h00;
        m_cnt   = 8'h00;
    endtask

    // One sample of the upstream counter plus config; the expected post-edge view is queued.
    task automatic cyc(input logic [15:0] cin, input logic en, input logic cv,
                       input logic [15:0] cm, input logic [7:0] cr);
        exp_t e;
        logic fresh, accept, hit;
        @(negedge clk);
        count_in   = cin;
        enable     = en;
        cfg_valid  = cv;
        cfg_match  = cm;
        cfg_repeat = cr;
        fresh  = !m_pvld || (cin != m_prev);
        e.wp   = m_pvld && (m_prev == 16'h0000) && (cin == 16'hffff);
        accept = cv && (m_state != M_ARMED);
        hit    = (m_state == M_ARMED) && en && fresh && (cin == m_match);
        e.mp   = hit;
        if (accept) begin
            m_match = cm;
            m_tgt   = (cr == 8'd0) ? 8'd1 : cr;
            m_cnt   = 8'd0;
            m_state = M_ARMED;
        end else if (hit) begin
            m_cnt = m_cnt + 8'd1;
            if (m_cnt == m_tgt) m_state = M_DONE;
        end
        m_prev = cin;
        m_pvld = 1'b1;
        e.ec   = m_cnt;
        e.busy = (m_state == M_ARMED);
        e.done = (m_state == M_DONE);
        e.rdy  = (m_state != M_ARMED);
        exp_q.push_back(e);
    endtask

    task automatic pass_down(input logic [15:0] start, input int n, input logic en);
        logic [15:0] v;
        v = start;
        for (int i = 0; i < n; i++) begin
            cyc(v, en, 1'b0, 16'h0000, 8'h00);
            v = v - 16'd1;
        end
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, ".cfg_ready"},   cfg_ready,   1);
        chk({tag, ".busy"},        busy,        0);
        chk({tag, ".done"},        done,        0);
        chk({tag, ".event_count"}, event_count, 0);
        chk({tag, ".match_pulse"}, match_pulse, 0);
        chk({tag, ".wrap_pulse"},  wrap_pulse,  0);
    endtask

    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("match_pulse", match_pulse, e.mp);
            chk("wrap_pulse",  wrap_pulse,  e.wp);
            chk("event_count", event_count, e.ec);
            chk("busy",        busy,        e.busy);
            chk("done",        done,        e.done);
            chk("cfg_ready",   cfg_ready,   e.rdy);
        end
    end

    initial begin
        logic [15:0] ucnt;
        logic        en;
        logic        cv;
        logic [15:0] cm;
        logic [7:0]  cr;
        int          r;

        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_cleared("reset");
        @(posedge clk);
        #3;
        reset = 1'b0;
        model_reset();

        // Wrap while idle and unconfigured
        pass_down(16'd2, 5, 1'b1);

        // match=3 repeat=2: two passes finish, a third is ignored
        cyc(16'd9, 1'b1, 1'b1, 16'h0003, 8'd2);
        pass_down(16'd6, 9, 1'b1);
        pass_down(16'd6, 9, 1'b1);
        pass_down(16'd6, 9, 1'b1);

        // Upstream held at reset value: one qualification only
        cyc(16'd5, 1'b1, 1'b1, 16'hffff, 8'd5);
        for (int i = 0; i < 10; i++) cyc(16'hffff, 1'b1, 1'b0, 16'h0000, 8'h00);

        // Async reset mid-ARMED with one event counted
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk_cleared("async_reset");
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b0;
        model_reset();

        // repeat=0 finishes on a single match
        cyc(16'd7, 1'b1, 1'b1, 16'h0002, 8'd0);
        pass_down(16'd5, 5, 1'b1);

        // Paused pass through the match value, then resume on the held value
        cyc(16'd9, 1'b1, 1'b1, 16'h0004, 8'd2);
        pass_down(16'd6, 3, 1'b0);
        cyc(16'd4, 1'b1, 1'b0, 16'h0000, 8'h00);
        pass_down(16'd3, 2, 1'b1);
        pass_down(16'd6, 5, 1'b1);
        pass_down(16'd6, 5, 1'b1);

        // Match and wrap on the same sample
        cyc(16'd1, 1'b1, 1'b1, 16'hffff, 8'd1);
        pass_down(16'd0, 3, 1'b1);

        // Randomized upstream behaviour and configuration traffic
        ucnt = 16'd10;
        for (int i = 0; i < 4000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 5)       ucnt = 16'($urandom_range(0, 12));
            else if (r < 10) ucnt = ucnt;
            else if (r < 12) ucnt = 16'hffff;
            else             ucnt = ucnt - 16'd1;
            en = ($urandom_range(0, 9) != 0);
            cv = ($urandom_range(0, 7) == 0);
            cm = ($urandom_range(0, 4) == 0) ? 16'hffff : 16'($urandom_range(0, 10));
            cr = 8'($urandom_range(0, 4));
            cyc(ucnt, en, cv, cm, cr);
        end

        repeat (3) @(posedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
